// File: rtl/apb_cfg_regs.sv
// APB completer holding the matrix-multiplier job configuration and start/done control.
// Optional feature: define APB_READBACK_EN to return register contents on prdata.
//
// state        | meaning
// IDLE         | waiting for psel; request fields captured on the way out
// ACCESS       | pready high; the write commits on the edge leaving this state
// WAIT_RELEASE | psel still held after completion; nothing is committed
module apb_cfg_regs #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        paddr,
  input  logic              psel,
  input  logic              pwrite,
  input  logic [15:0]       pwdata,
  output logic [15:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ADDR_W-1:0] a_base,
  output logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] c_base,
  output logic [DIM_W-1:0]  m_dim,
  output logic [DIM_W-1:0]  n_dim,
  output logic [DIM_W-1:0]  p_dim,
  output logic              start,
  input  logic              core_done,
  output logic              busy,
  output logic              done_apb
);

  localparam logic [2:0] REG_A      = 3'd0;
  localparam logic [2:0] REG_B      = 3'd1;
  localparam logic [2:0] REG_C      = 3'd2;
  localparam logic [2:0] REG_M      = 3'd3;
  localparam logic [2:0] REG_N      = 3'd4;
  localparam logic [2:0] REG_P      = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACCESS       = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  hold_addr;
  logic        hold_write;
  logic [15:0] hold_wdata;
  logic        hold_err;
  logic        take;
  logic        commit;
  logic        start_go;
  logic        dims_ok;
  logic        req_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (psel) state_nxt = ACCESS;
      ACCESS:       state_nxt = psel ? WAIT_RELEASE : IDLE;
      WAIT_RELEASE: if (!psel) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  assign take     = (state == IDLE) && psel;
  assign dims_ok  = (|m_dim) && (|n_dim) && (|p_dim);
  assign commit   = (state == ACCESS) && hold_write && !hold_err;
  assign start_go = commit && (hold_addr == REG_CTRL) && hold_wdata[0];

  // Error is decided when the request is captured so pslverr and the commit always agree.
  always_comb begin
    req_err = 1'b0;
    if (pwrite) begin
      if (paddr <= REG_P)
        req_err = busy;
      else if (paddr == REG_CTRL)
        req_err = pwdata[0] && (busy || !dims_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_wdata <= '0;
      hold_err   <= 1'b0;
    end else if (take) begin
      hold_addr  <= paddr;
      hold_write <= pwrite;
      hold_wdata <= pwdata;
      hold_err   <= req_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      pready  <= take;
      pslverr <= take && req_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_base <= '0;
      b_base <= '0;
      c_base <= '0;
      m_dim  <= '0;
      n_dim  <= '0;
      p_dim  <= '0;
    end else if (commit) begin
      case (hold_addr)
        REG_A:   a_base <= ADDR_W'(hold_wdata);
        REG_B:   b_base <= ADDR_W'(hold_wdata);
        REG_C:   c_base <= ADDR_W'(hold_wdata);
        REG_M:   m_dim  <= DIM_W'(hold_wdata);
        REG_N:   n_dim  <= DIM_W'(hold_wdata);
        REG_P:   p_dim  <= DIM_W'(hold_wdata);
        default: ;
      endcase
    end
  end

  // A launch can only be accepted with busy low, so it never collides with core_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start    <= 1'b0;
      busy     <= 1'b0;
      done_apb <= 1'b0;
    end else begin
      start <= start_go;
      if (start_go) begin
        busy     <= 1'b1;
        done_apb <= 1'b0;
      end else if (core_done && busy) begin
        busy     <= 1'b0;
        done_apb <= 1'b1;
      end else if (commit && (hold_addr == REG_STATUS) && hold_wdata[1]) begin
        done_apb <= 1'b0;
      end
    end
  end

`ifdef APB_READBACK_EN
  logic [15:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (paddr)
      REG_A:      rd_mux = 16'(a_base);
      REG_B:      rd_mux = 16'(b_base);
      REG_C:      rd_mux = 16'(c_base);
      REG_M:      rd_mux = 16'(m_dim);
      REG_N:      rd_mux = 16'(n_dim);
      REG_P:      rd_mux = 16'(p_dim);
      REG_STATUS: rd_mux = {14'd0, done_apb, busy};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prdata <= '0;
    else          prdata <= take ? rd_mux : 16'd0;
  end
`else
  assign prdata = '0;
`endif

endmodule

// File: tb/tb_apb_cfg_regs.sv
// Directed bench for apb_cfg_regs: expected APB responses are queued at stimulus
// time and popped when pready is observed; side effects are checked after each transfer.
module tb_apb_cfg_regs;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  paddr = '0;
  logic        psel = 1'b0;
  logic        pwrite = 1'b0;
  logic [15:0] pwdata = '0;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [15:0] a_base, b_base, c_base, m_dim, n_dim, p_dim;
  logic        start;
  logic        core_done = 1'b0;
  logic        busy;
  logic        done_apb;

  int checks = 0;
  int errors = 0;
  int start_count = 0;

  typedef struct {
    logic        is_read;
    logic        err;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb[$];

  apb_cfg_regs #(.ADDR_W(16), .DIM_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .paddr(paddr), .psel(psel), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .m_dim(m_dim), .n_dim(n_dim), .p_dim(p_dim),
    .start(start), .core_done(core_done), .busy(busy), .done_apb(done_apb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start) start_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Read expectation depends on whether the readback mux is built.
  function automatic logic [15:0] rb(input logic [15:0] v);
`ifdef APB_READBACK_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  // One APB transfer; psel held for 'hold' cycles (>=2). cd pulses core_done
  // during the ACCESS cycle so it lands on the same edge as the commit.
  task automatic xfer(input string tag, input logic [2:0] a, input logic w,
                      input logic [15:0] d, input logic e, input logic [15:0] rd,
                      input int hold, input logic cd);
    exp_t x;
    exp_t got;
    int   n;
    x.is_read = !w; x.err = e; x.rdata = rd;
    sb.push_back(x);
    @(negedge clk);
    paddr = a; pwrite = w; pwdata = d; psel = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready && n < 10);
    got = sb.pop_front();
    if (!pready) begin
      check({tag, "_timeout"}, 32'(pready), 32'd1);
    end else begin
      check({tag, "_pslverr"}, 32'(pslverr), 32'(got.err));
      if (got.is_read) check({tag, "_prdata"}, 32'(prdata), 32'(got.rdata));
    end
    if (cd) core_done = 1'b1;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      core_done = 1'b0;
      if (i == 1) check({tag, "_pready_drop"}, 32'(pready), 32'd0);
    end
    psel = 1'b0;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_outputs", {a_base, b_base}, 32'd0);
    check("rst_dims", {m_dim | n_dim | p_dim, prdata}, 32'd0);
    check("rst_ctl", {27'd0, start, busy, done_apb, pready, pslverr}, 32'd0);
    reset_n = 1'b1;

    xfer("status_rst", 3'd7, 1'b0, 16'h0, 1'b0, rb(16'h0000), 2, 1'b0);

    xfer("wr_a", 3'd0, 1'b1, 16'h0000, 1'b0, 16'h0, 2, 1'b0);
    xfer("wr_b", 3'd1, 1'b1, 16'h0000, 1'b0, 16'h0, 2, 1'b0);
    xfer("wr_c", 3'd2, 1'b1, 16'hC0DE, 1'b0, 16'h0, 2, 1'b0);
    check("c_base", 32'(c_base), 32'h0000C0DE);
    xfer("wr_m", 3'd3, 1'b1, 16'd32, 1'b0, 16'h0, 2, 1'b0);
    xfer("wr_n", 3'd4, 1'b1, 16'd32, 1'b0, 16'h0, 2, 1'b0);
    xfer("wr_p", 3'd5, 1'b1, 16'd32, 1'b0, 16'h0, 2, 1'b0);
    check("no_start_yet", 32'(start_count), 32'd0);

    xfer("launch", 3'd6, 1'b1, 16'h0001, 1'b0, 16'h0, 2, 1'b0);
    check("launch_starts", 32'(start_count), 32'd1);
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_dims", {m_dim, n_dim} ^ {16'd32, p_dim}, 32'd0);
    check("launch_p", 32'(p_dim), 32'd32);
    xfer("status_busy", 3'd7, 1'b0, 16'h0, 1'b0, rb(16'h0001), 2, 1'b0);

    xfer("wp_m", 3'd3, 1'b1, 16'd8, 1'b1, 16'h0, 2, 1'b0);
    check("wp_m_kept", 32'(m_dim), 32'd32);
    xfer("wp_ctrl", 3'd6, 1'b1, 16'h0001, 1'b1, 16'h0, 2, 1'b0);
    check("wp_no_start", 32'(start_count), 32'd1);
    xfer("status_bit0_wr", 3'd7, 1'b1, 16'h0001, 1'b0, 16'h0, 2, 1'b0);
    check("busy_kept", 32'(busy), 32'd1);

    pulse_done();
    check("done_busy", 32'(busy), 32'd0);
    check("done_flag", 32'(done_apb), 32'd1);
    pulse_done();
    check("idle_core_done", {busy, done_apb}, 32'd1);
    xfer("status_done", 3'd7, 1'b0, 16'h0, 1'b0, rb(16'h0002), 2, 1'b0);
    xfer("w1c", 3'd7, 1'b1, 16'h0002, 1'b0, 16'h0, 2, 1'b0);
    check("w1c_clear", 32'(done_apb), 32'd0);

    xfer("wr_n0", 3'd4, 1'b1, 16'd0, 1'b0, 16'h0, 2, 1'b0);
    xfer("zero_dim", 3'd6, 1'b1, 16'h0001, 1'b1, 16'h0, 2, 1'b0);
    check("zero_no_start", 32'(start_count), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    xfer("ctrl_hi_bits", 3'd6, 1'b1, 16'hFFFE, 1'b0, 16'h0, 2, 1'b0);
    check("ctrl_hi_no_start", 32'(start_count), 32'd1);

    xfer("wr_p_rb", 3'd5, 1'b1, 16'h1234, 1'b0, 16'h0, 2, 1'b0);
    xfer("rd_p", 3'd5, 1'b0, 16'h0, 1'b0, rb(16'h1234), 2, 1'b0);
    xfer("rd_ctrl", 3'd6, 1'b0, 16'h0, 1'b0, 16'h0000, 2, 1'b0);

    xfer("wr_n32", 3'd4, 1'b1, 16'd32, 1'b0, 16'h0, 2, 1'b0);
    xfer("long_launch", 3'd6, 1'b1, 16'h0001, 1'b0, 16'h0, 6, 1'b0);
    check("long_one_start", 32'(start_count), 32'd2);
    xfer("set_wins", 3'd7, 1'b1, 16'h0002, 1'b0, 16'h0, 2, 1'b1);
    check("set_wins_done", {busy, done_apb}, 32'd1);

    @(negedge clk);
    paddr = 3'd3; pwrite = 1'b1; pwdata = 16'd7; psel = 1'b1;
    @(negedge clk);
    check("mid_access_pready", 32'(pready), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_pready", {pready, busy, done_apb}, 32'd0);
    psel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("async_rst_lost", {m_dim, p_dim}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
